muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the register file and consumes its rsdata/rtdata read ports.
- Executes MULT/MULTU/DIV/DIVU over 32 cycles and MTHI/MTLO in one cycle.
- Exposes HI/LO to the writeback mux for MFHI/MFLO; busy is the stall request to the PC/control logic.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  issue request, sampled on the rising edge.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- rsdata  in  WIDTH  operand A (dividend / multiplicand / move source).
- rtdata  in  WIDTH  operand B (divisor / multiplier).
- busy  out  1  iterative operation in progress; issue is blocked.
- done  out  1  one-cycle pulse; HI/LO hold a new mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation and leaves nothing pending.
- States:
  - IDLE: accepts issue.
  - RUN: one iteration per cycle; 5-bit (log2 WIDTH) counter.
- Issue: accepted only when start=1 and state=IDLE. start while busy=1 is ignored, with no queueing.
- MTHI/MTLO: on the accept edge, hi<=rsdata (MTHI) or lo<=rsdata (MTLO). Stays IDLE; busy and done unaffected (done=0 next cycle).
- Mul/div timing, for an op accepted at the edge ending cycle T:
  - Operand magnitudes and result sign are latched on that edge.
  - busy=1 in cycles T+1..T+32.
  - The 32nd iteration edge writes hi/lo.
  - Cycle T+33: busy=0, done=1, new hi/lo visible. A new start in T+33 is accepted.
- done is registered and high for exactly one cycle. It is 0 in all other cycles.
- hi/lo keep their previous values during RUN, so MFHI during busy reads old values. Control must stall.
- Multiply: shift-add on magnitudes, 2*WIDTH-bit product, {hi,lo}=product.
  - Signed ops take magnitudes of both operands.
  - The product is negated if sign(A) xor sign(B).
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign. Example: -7/2 gives q=-3, r=-1.
- Divide by zero (DIV and DIVU): lo=all-ones, hi=rsdata unchanged. No exception.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
- Operands are latched at accept; later rsdata/rtdata changes have no effect.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 110 (MADD) / 111 (MSUB) run as a signed 32-cycle multiply, same timing as MULT.
  - At completion: {hi,lo} <= {hi,lo} + product (MADD) or {hi,lo} - product (MSUB), modulo 2^(2*WIDTH).
  - The accumulate operand is the {hi,lo} value at completion time.
- Undefined: ops 110/111 are ignored, with no state change, busy=0 and done=0.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> cycles T+1..T+32 busy=1; cycle T+33 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle; busy and done stay 0.
- DIVU 100/7 issued, start pulsed again at T+5 with MULT 3*3 -> second start ignored; T+33 lo=14, hi=2. A start at T+33 is accepted.
- MULT issued, rst asserted asynchronously mid-cycle at T+10 -> busy, done, hi and lo go to 0 immediately; no done pulse after reset release.
- With MULDIV_MADD_EN defined: MTLO 5, MTHI 0, then MADD 3*4 -> lo=17, hi=0; MSUB 3*4 -> lo=5. Without the macro, op 110 leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; one iteration per clock, WIDTH iterations.
// Build option MULDIV_MADD_EN enables MADD/MSUB (op 110/111) accumulating into {hi,lo}.
//   state  | meaning
//   S_IDLE | waiting for issue; MTHI/MTLO complete here in one edge
//   S_RUN  | shift-add multiply or restoring divide, cnt_q counts down to 0
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rsdata,
  input  logic [WIDTH-1:0] rtdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 div0_q, div0_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [1:0]           acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic                 op_div;
  logic                 sgn_a, sgn_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shl;
  logic [WIDTH:0]       div_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   mac;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV) || (op[2:1] == 2'b11);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    sgn_a     = op_signed & rsdata[WIDTH-1];
    sgn_b     = op_signed & rtdata[WIDTH-1];
    mag_a     = sgn_a ? (~rsdata + 1'b1) : rsdata;
    mag_b     = sgn_b ? (~rtdata + 1'b1) : rtdata;
  end

  // One iteration of each algorithm; work_q is {acc, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    div_shl  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_sub  = div_shl - {1'b0, opnd_q};
    div_next = div_sub[WIDTH] ? {div_shl[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                              : {div_sub[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    step     = is_div_q ? div_next : mul_next;
  end

  always_comb begin
    prod_s = qneg_q ? (~step + 1'b1) : step;
    case (acc_q)
      ACC_ADD: mac = {hi_q, lo_q} + prod_s;
      ACC_SUB: mac = {hi_q, lo_q} - prod_s;
      default: mac = prod_s;
    endcase
    quot = qneg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
    rem  = rneg_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
`ifdef MULDIV_MADD_EN
            , OP_MADD, OP_MSUB
`endif
            : begin
              state_d  = S_RUN;
              busy_d   = 1'b1;
              cnt_d    = CNT_LAST;
              is_div_d = op_div;
              div0_d   = op_div && (rtdata == '0);
              qneg_d   = sgn_a ^ sgn_b;
              rneg_d   = sgn_a;
              opnd_d   = op_div ? mag_b : mag_a;
              work_d   = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              acc_d    = ACC_NONE;
`ifdef MULDIV_MADD_EN
              if (op == OP_MADD) acc_d = ACC_ADD;
              if (op == OP_MSUB) acc_d = ACC_SUB;
`endif
            end
            OP_MTHI: hi_d = rsdata;
            OP_MTLO: lo_d = rsdata;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        work_d = step;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_div_q) begin
            // Divide by zero leaves the dividend in hi; remainder sign fix-up already yields rsdata.
            lo_d = div0_q ? {WIDTH{1'b1}} : quot;
            hi_d = rem;
          end else begin
            {hi_d, lo_d} = mac;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= ACC_NONE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of mul/div results plus sequences for
// MTHI/MTLO, ignored issue while busy, async reset mid-operation and ops 110/111.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rsdata = '0;
  logic [31:0] rtdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rsdata(rsdata), .rtdata(rtdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues an op and follows it cycle by cycle to T+33; optionally pokes a second start at T+5.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string name, input bit poke);
    @(negedge clk);
    start = 1'b1; op = o; rsdata = a; rtdata = b;
    @(posedge clk); #1;
    start = 1'b0; rsdata = ~a; rtdata = b ^ 32'h5a5a_5a5a;
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check({name, " busy"}, 32'(busy), 32'd1);
      if (k == 1 || k == 16) begin
        check({name, " done_run"}, 32'(done), 32'd0);
        check({name, " hi_hold"}, hi, prev_hi);
        check({name, " lo_hold"}, lo, prev_lo);
      end
      if (poke && k == 5) begin
        start = 1'b1; op = 3'b000; rsdata = 32'd3; rtdata = 32'd3;
      end else if (poke && k == 6) begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    check({name, " busy_end"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " hi"}, hi, ehi);
    check({name, " lo"}, lo, elo);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  task automatic one_cycle_op(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rsdata = a; rtdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    bit flag;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b000, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 32'h5678_0000};
    vecs[7]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9]  = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[10] = '{3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F};
    vecs[11] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[12] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo,
             $sformatf("vec%0d", i), 1'b0);

`ifdef MULDIV_MADD_EN
    one_cycle_op(3'b101, 32'd5);
    one_cycle_op(3'b100, 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd5;
    run_op(3'b110, 32'd3, 32'd4, 32'd0, 32'd17, "madd", 1'b0);
    run_op(3'b111, 32'd3, 32'd4, 32'd0, 32'd5, "msub", 1'b0);
`else
    for (int o = 6; o <= 7; o++) begin
      one_cycle_op(3'(o), 32'hDEAD_BEEF);
      check("op11x busy", 32'(busy), 32'd0);
      check("op11x done", 32'(done), 32'd0);
      check("op11x hi", hi, prev_hi);
      check("op11x lo", lo, prev_lo);
      @(posedge clk); #1;
      check("op11x busy2", 32'(busy), 32'd0);
      check("op11x done2", 32'(done), 32'd0);
    end
`endif

    // Async reset in the middle of cycle T+10 of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'b000; rsdata = 32'd5; rtdata = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("pre_rst busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    check("mid_rst hi", hi, 32'd0);
    check("mid_rst lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) flag = 1'b1;
    end
    check("post_rst quiet", 32'(flag), 32'd0);
    check("post_rst hi", hi, 32'd0);
    prev_hi = '0;
    prev_lo = '0;

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = 3'b100; rsdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi lo", lo, 32'd0);
    check("mthi busy", 32'(busy), 32'd0);
    check("mthi done", 32'(done), 32'd0);
    op = 3'b101; rsdata = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi", hi, 32'h1234_5678);
    check("mtlo busy", 32'(busy), 32'd0);
    check("mtlo done", 32'(done), 32'd0);
    prev_hi = 32'h1234_5678;
    prev_lo = 32'h9ABC_DEF0;

    // Second start at T+5 is dropped; an issue right in T+33 is taken.
    run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_poke", 1'b1);
    run_op(3'b000, 32'd3, 32'd3, 32'd0, 32'd9, "mult_t33", 1'b0);
    @(posedge clk); #1;
    check("final done", 32'(done), 32'd0);
    check("final busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
